// File: rtl/bus_rbtr_pkg.sv
// bus_rbtr_pkg: shared types, mode constants and destination decode for the bus arbiter
package bus_rbtr_pkg;

    typedef enum logic [1:0] {IDLE, POP, PUSH} rbtr_state_t;

    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    // mask is sized for the largest supported bus (16 terminals)
    typedef struct packed {
        logic [15:0] mask;
        logic        err;
    } dst_t;

    // broadcast wins over the range check, so a broadcast id below drvrs still fans out
    function automatic dst_t dst_decode(input logic [31:0] id, input int src, input int drvrs,
                                        input logic [31:0] broadcast);
        dst_t r;
        r.mask = '0;
        r.err  = 1'b0;
        if (id == broadcast)
            r.mask = 16'((33'd1 << drvrs) - 33'd1) & ~(16'd1 << src);
        else if (id < 32'(drvrs))
            r.mask = 16'd1 << id;
        else
            r.err = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bus_rbtr_rr_pick.sv
// rr_pick: combinational source selection, round-robin from ptr_i or lowest index first
module rr_pick
    import bus_rbtr_pkg::*;
#(
    parameter int n    = 4,
    parameter int mode = MODE_RR
) (
    input  logic [n-1:0]         req_i,
    input  logic [$clog2(n)-1:0] ptr_i,
    output logic [$clog2(n)-1:0] sel_o,
    output logic                 vld_o
);

    localparam int PW = $clog2(n);

    int base;
    int idx;

    // scan offsets from the top down so the nearest pending terminal to base wins
    always_comb begin
        base  = (mode == MODE_PRIO) ? 0 : int'(ptr_i);
        idx   = 0;
        sel_o = '0;
        vld_o = |req_i;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (base + k) % n;
            if (req_i[idx[PW-1:0]]) sel_o = idx[PW-1:0];
        end
    end

endmodule

// File: rtl/bus_rbtr_rr.sv
// bus_rbtr_rr: shared-bus arbiter moving one packet per three cycles from terminal FIFOs to terminals
module bus_rbtr_rr
    import bus_rbtr_pkg::*;
#(
    parameter int               drvrs     = 4,
    parameter int               pckg_sz   = 16,
    parameter int               id_w      = 8,
    parameter logic [id_w-1:0]  broadcast = {id_w{1'b1}},
    parameter int               mode      = MODE_RR
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic                            err_dst,
    output logic [15:0]                     pkt_cnt
);

    localparam int PW = $clog2(drvrs);

    rbtr_state_t        state_q;
    logic [PW-1:0]      src_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [pckg_sz-1:0] pkt_q;
    logic [PW-1:0]      pick_sel;
    logic               pick_vld;
    dst_t               dec;

    rr_pick #(.n(drvrs), .mode(mode)) u_pick (
        .req_i (pndng),
        .ptr_i (rr_ptr_q),
        .sel_o (pick_sel),
        .vld_o (pick_vld)
    );

    // decode straight from the FIFO head so push/err can be registered on the closing POP edge
    always_comb dec = dst_decode(32'(D_pop[src_q][pckg_sz-1 -: id_w]), int'(src_q), drvrs, 32'(broadcast));

    assign D_push = {drvrs{pkt_q}};

    // IDLE picks a source, POP strobes it and latches data, PUSH delivers and returns to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            pop      <= '0;
            push     <= '0;
            err_dst  <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        src_q   <= pick_sel;
                        pop     <= drvrs'(1) << pick_sel;
                        state_q <= POP;
                    end
                end
                POP: begin
                    pop     <= '0;
                    pkt_q   <= D_pop[src_q];
                    push    <= dec.mask[drvrs-1:0];
                    err_dst <= dec.err;
                    if (|dec.mask) pkt_cnt <= pkt_cnt + 16'd1;
                    if (mode == MODE_RR) rr_ptr_q <= (src_q == PW'(drvrs - 1)) ? '0 : src_q + PW'(1);
                    state_q <= PUSH;
                end
                PUSH: begin
                    push    <= '0;
                    err_dst <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rbtr_rr.sv
// tb_bus_rbtr_rr: table vectors, corner sequences and random traffic against a behavioural arbiter model
module tb_bus_rbtr_rr;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        pndng;
    logic [3:0][15:0]  D_pop;
    logic [3:0]        pop_r, push_r, pop_p, push_p;
    logic [3:0][15:0]  dp_r, dp_p;
    logic              err_r, err_p;
    logic [15:0]       cnt_r, cnt_p;

    bus_rbtr_rr #(.drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF), .mode(0)) dut_r (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_r), .push(push_r), .D_push(dp_r), .err_dst(err_r), .pkt_cnt(cnt_r)
    );

    bus_rbtr_rr #(.drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF), .mode(1)) dut_p (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_p), .push(push_p), .D_push(dp_p), .err_dst(err_p), .pkt_cnt(cnt_p)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ptr_m = 0;
    logic [15:0] cnt_mr = '0;
    logic [15:0] cnt_mp = '0;
    logic [3:0]  cap_pop_r, cap_pop_p, cap_push_r;
    logic        cap_err_r;
    logic [15:0] cap_lane_r;

    typedef struct {
        logic [3:0]       pn;
        logic [3:0][15:0] d;
        logic [3:0]       e_pop;
        logic [3:0]       e_push;
        logic             e_err;
        logic [15:0]      e_pkt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // first pending terminal at or after ptr, wrapping
    function automatic int pick(input logic [3:0] pn, input int ptr);
        for (int k = 0; k < 4; k++)
            if (pn[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] dst(input logic [15:0] d, input int s, output logic e);
        int id;
        id = int'(d[15:8]);
        e = 1'b0;
        if (id == 255) return 4'hF & ~(4'b0001 << s);
        if (id < 4) return 4'b0001 << id;
        e = 1'b1;
        return 4'h0;
    endfunction

    // one full IDLE->POP->PUSH->IDLE transfer, checked cycle by cycle on both arbiters
    task automatic run_xfer(input string tag);
        int sr, sp;
        logic er, ep;
        logic [3:0] mr, mp;
        sr = pick(pndng, ptr_m);
        sp = pick(pndng, 0);
        mr = dst(D_pop[sr], sr, er);
        mp = dst(D_pop[sp], sp, ep);
        @(posedge clk);
        @(negedge clk);
        cap_pop_r = pop_r;
        cap_pop_p = pop_p;
        chk({tag, " pop_rr"}, 64'(pop_r), 64'(4'b0001 << sr));
        chk({tag, " pop_prio"}, 64'(pop_p), 64'(4'b0001 << sp));
        chk({tag, " push_in_pop"}, 64'({push_r, push_p, err_r, err_p}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        if (mr != 0) cnt_mr = cnt_mr + 16'd1;
        if (mp != 0) cnt_mp = cnt_mp + 16'd1;
        cap_push_r = push_r;
        cap_err_r  = err_r;
        cap_lane_r = dp_r[3];
        chk({tag, " push_rr"}, 64'(push_r), 64'(mr));
        chk({tag, " err_rr"}, 64'(err_r), 64'(er));
        chk({tag, " push_prio"}, 64'(push_p), 64'(mp));
        chk({tag, " err_prio"}, 64'(err_p), 64'(ep));
        chk({tag, " pop_in_push"}, 64'({pop_r, pop_p}), 64'(0));
        if (mr != 0) chk({tag, " dpush_rr"}, dp_r, {4{D_pop[sr]}});
        if (mp != 0) chk({tag, " dpush_prio"}, dp_p, {4{D_pop[sp]}});
        chk({tag, " cnt_rr"}, 64'(cnt_r), 64'(cnt_mr));
        chk({tag, " cnt_prio"}, 64'(cnt_p), 64'(cnt_mp));
        ptr_m = (sr + 1) % 4;
        @(posedge clk);
        #1;
        chk({tag, " idle_quiet"}, 64'({pop_r, push_r, err_r, pop_p, push_p, err_p}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 64'h0000_0000_0000_02AB, 4'b0001, 4'b0100, 1'b0, 16'h02AB};
        tbl[1] = '{4'b0100, 64'h0000_FF5A_0000_0000, 4'b0100, 4'b1011, 1'b0, 16'hFF5A};
        tbl[2] = '{4'b0010, 64'h0000_0000_0711_0000, 4'b0010, 4'b0000, 1'b1, 16'h0000};
        tbl[3] = '{4'b1000, 64'h0355_0000_0000_0000, 4'b1000, 4'b1000, 1'b0, 16'h0355};
        tbl[4] = '{4'b0001, 64'h0000_0000_0000_04C3, 4'b0001, 4'b0000, 1'b1, 16'h0000};

        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_rr", {pop_r, push_r, err_r, cnt_r}, 64'(0));
        chk("reset_dpush", dp_r, 64'(0));
        chk("reset_prio", {pop_p, push_p, err_p, cnt_p}, 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            pndng = tbl[i].pn;
            D_pop = tbl[i].d;
            run_xfer($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_pop", i), 64'(cap_pop_r), 64'(tbl[i].e_pop));
            chk($sformatf("vec%0d tbl_push", i), 64'(cap_push_r), 64'(tbl[i].e_push));
            chk($sformatf("vec%0d tbl_err", i), 64'(cap_err_r), 64'(tbl[i].e_err));
            if (tbl[i].e_push != 0) chk($sformatf("vec%0d tbl_pkt", i), 64'(cap_lane_r), 64'(tbl[i].e_pkt));
        end
        chk("cnt_after_table", 64'(cnt_r), 64'(3));

        pndng = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_no_req", 64'({pop_r, push_r, err_r}), 64'(0));

        // fresh reset, then all four pending: grants rotate in RR, stick at 0 in priority mode
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ptr_m = 0; cnt_mr = '0; cnt_mp = '0;
        pndng = 4'b1111;
        D_pop = {16'h0211, 16'h0122, 16'h0333, 16'h0044};
        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("rr%0d", i));
            chk($sformatf("rr%0d grant_rr", i), 64'(cap_pop_r), 64'(4'b0001 << (i % 4)));
            chk($sformatf("rr%0d grant_prio", i), 64'(cap_pop_p), 64'(1));
        end

        for (int i = 0; i < 40; i++) begin
            do pndng = 4'($urandom); while (pndng == 0);
            for (int j = 0; j < 4; j++) begin
                logic [7:0] id;
                case ($urandom % 4)
                    0: id = 8'($urandom % 4);
                    1: id = 8'hFF;
                    2: id = 8'($urandom);
                    default: id = 8'($urandom % 4);
                endcase
                D_pop[j] = {id, 8'($urandom)};
            end
            run_xfer($sformatf("rnd%0d", i));
        end

        // reset landing in the middle of PUSH must clear outputs before any clock edge
        pndng = 4'b0001;
        D_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0155};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("midrst push_before", 64'(push_r), 64'(4'b0010));
        reset = 1'b1;
        #1;
        chk("midrst push_async", 64'({push_r, push_p, pop_r, pop_p, err_r}), 64'(0));
        chk("midrst cnt", 64'({cnt_r, cnt_p}), 64'(0));
        chk("midrst dpush", dp_r, 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        ptr_m = 0; cnt_mr = '0; cnt_mp = '0;
        pndng = 4'b1111;
        D_pop = {16'h0011, 16'h0022, 16'h0033, 16'h0102};
        run_xfer("post_reset");
        chk("post_reset ptr_zero", 64'(cap_pop_r), 64'(1));

        // preload near the top of the counter and watch it wrap
        force dut_r.pkt_cnt = 16'hFFFE;
        #1 release dut_r.pkt_cnt;
        cnt_mr = 16'hFFFE;
        pndng = 4'b0001;
        D_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0377};
        run_xfer("wrap_a");
        chk("wrap_ffff", 64'(cnt_r), 64'(16'hFFFF));
        run_xfer("wrap_b");
        chk("wrap_zero", 64'(cnt_r), 64'(16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rbtr_rr.md
# bus_rbtr_rr

Parametrised shared-bus arbiter for the `drvrs`-terminal bus environment, the successor to `bs_gnrtr_n_rbtr`. It pulls packets from per-terminal input FIFOs, decodes the destination ID field, and pushes each packet to one terminal or to all other terminals (broadcast). Over the previous generation it adds:

- selectable round-robin or fixed-priority arbitration;
- a parametrised ID field width;
- invalid-destination detection;
- a delivered-packet counter.

It sits between the terminal FIFOs and the `bus_if` agents/monitors.

## Interface
Parameters:
- `drvrs`, 4: number of bus terminals (2..16).
- `pckg_sz`, 16: packet width in bits; must be ≥ `id_w` + 1.
- `id_w`, 8: width of the destination ID field, `pkt[pckg_sz-1 -: id_w]`.
- `broadcast`, `{id_w{1'b1}}`: ID value meaning "all terminals except the source".
- `mode`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pndng`  in  `drvrs`  terminal i has a packet at its FIFO head.
- `D_pop`  in  `drvrs`×`pckg_sz`  FIFO head data per terminal; valid while `pndng[i]`.
- `pop`  out  `drvrs`  one-cycle pop strobe to terminal i's FIFO.
- `push`  out  `drvrs`  one-cycle push strobe into terminal i.
- `D_push`  out  `drvrs`×`pckg_sz`  delivered packet, the same value on every lane.
- `err_dst`  out  1  one-cycle pulse: packet dropped because its ID is not < `drvrs` and not `broadcast`.
- `pkt_cnt`  out  16  count of delivered packets; wraps at 2^16.

## Operation
FSM states: `IDLE`, `POP`, `PUSH`.

- **IDLE**
  - If `|pndng` is 0, stay in IDLE.
  - Otherwise select `src`:
    - RR: first set bit of `pndng` at or after `rr_ptr`, searching upward with wrap.
    - Fixed priority: lowest set index.
  - Register `src`, then go to POP.
- **POP**
  - Drive `pop[src]=1` for this cycle only.
  - On the closing posedge, latch `D_pop[src]` into `pkt`.
  - In RR mode, set `rr_ptr <= (src+1) mod drvrs`.
  - Go to PUSH.
- **PUSH**
  - Decode `id = pkt[pckg_sz-1 -: id_w]`:
    - `id == broadcast`: `push[j]=1` for every j ≠ `src`.
    - `id < drvrs`: `push[id]=1`. A self-addressed packet (`id == src`) is delivered normally.
    - Otherwise: no push; `err_dst=1`.
  - `pkt_cnt` increments by 1 when any push occurs; a broadcast counts as one packet.
  - Go to IDLE.
- `D_push` lanes hold `pkt` from PUSH onward and keep the value until the next PUSH.
- `broadcast` is compared before the range check, so a broadcast value < `drvrs` is always treated as broadcast.
- `pndng[src]` dropping during POP (should not happen with a compliant FIFO): the pop is still issued and the latched data is used as-is.

## Timing
- Reset values: `pop=0`, `push=0`, `D_push=0`, `err_dst=0`, `pkt_cnt=0`, `rr_ptr=0`, state `IDLE`.
- Throughput: one packet per 3 cycles.
  - `pndng` is seen in IDLE at cycle n, `pop` is asserted in cycle n+1, `push`/`err_dst` in cycle n+2.
  - The next IDLE decision happens at cycle n+3.
- `pop`, `push` and `err_dst` are all registered, single-cycle, mutually exclusive in time, and never asserted in IDLE.
- Reset asserted mid-transfer:
  - outputs clear asynchronously;
  - the in-flight packet is lost (already popped, never pushed);
  - `pkt_cnt` restarts at 0.
- Simultaneous requests: exactly one grant per transfer. RR guarantees every pending terminal is served within `drvrs` transfers.
- `pkt_cnt` wraps from 16'hFFFF to 0 with no flag.

## Structure
- Shared package `bus_rbtr_pkg`:
  - `typedef enum logic [1:0] {IDLE, POP, PUSH} rbtr_state_t`;
  - localparams `MODE_RR=0` and `MODE_PRIO=1`;
  - function `dst_decode(id, src, drvrs, broadcast)`, which returns the push mask and the error bit.
- One sub-module, `rr_pick #(.n(drvrs), .mode(mode))`: combinational pick of `src` from `pndng` and `rr_ptr`, with a valid output. The top level owns `rr_ptr`, the FSM, the data latch and the counter.

## Test plan
All scenarios use `drvrs=4`, `pckg_sz=16`, `id_w=8`, `broadcast=8'hFF`.

1. Unicast:
   - Stimulus: `pndng=4'b0001`, `D_pop[0]=16'h02AB`.
   - Expected: `pop[0]` in cycle 1, then `push=4'b0100` with `D_push=16'h02AB` in cycle 2; `pkt_cnt=1`.
2. Broadcast:
   - Stimulus: terminal 2 sends `16'hFF5A`.
   - Expected: `push=4'b1011`, all lanes `16'hFF5A`; `pkt_cnt` +1.
3. Invalid destination:
   - Stimulus: terminal 1 sends `16'h0711`.
   - Expected: `pop[1]` asserted, `push=0`, `err_dst` one-cycle pulse, `pkt_cnt` unchanged.
4. Round-robin (`mode=0`):
   - Stimulus: all four `pndng` held high for 8 transfers.
   - Expected grant order 0,1,2,3,0,1,2,3.
   - Same stimulus with `mode=1`: grant is always 0.
5. Reset mid-transfer:
   - Stimulus: assert `reset` during PUSH.
   - Expected: `push` falls without waiting for a clock edge, state returns to IDLE, `pkt_cnt=0`, `rr_ptr=0`.
6. Counter wrap:
   - Stimulus: preload via 65536 deliveries (or a force).
   - Expected: `pkt_cnt` goes 16'hFFFF → 16'h0000.
